// File: rtl/axi_burst_splitter_pkg.sv
// Shared constants, AXI field-width defines and FSM state type for the AXI burst splitter.
`ifndef BW_AXI_ALEN
`define BW_AXI_ALEN 8
`endif
`ifndef BW_AXI_ASIZE
`define BW_AXI_ASIZE 3
`endif
`ifndef BW_AXI_ABURST
`define BW_AXI_ABURST 2
`endif

package axi_burst_splitter_pkg;

  localparam logic [`BW_AXI_ABURST-1:0] AXI_BURST_INCR   = 2'b01;
  localparam int                        AXI_4KB_BOUNDARY = 4096;
  localparam int                        BW_4KB_OFFSET    = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/axi_burst_len_calc.sv
// Combinational burst sizing: beats = min(remaining, MAX_BURST_LEN, beats left before the
// next 4 KB boundary), plus the start address of the following burst.
module axi_burst_len_calc
  import axi_burst_splitter_pkg::*;
#(
  parameter int BW_ADDR       = 32,
  parameter int BW_NUM_BEAT   = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [BW_ADDR-1:0]       i_addr,
  input  logic [BW_NUM_BEAT-1:0]   i_remaining,
  input  logic [`BW_AXI_ASIZE-1:0] i_size,
  output logic [BW_NUM_BEAT-1:0]   o_beats,
  output logic [BW_ADDR-1:0]       o_next_addr
);

  logic [31:0] w_to4k;
  logic [31:0] w_rem;
  logic [31:0] w_cap;
  logic [31:0] w_min;

  // Address is size-aligned, so the 4 KB distance in beats is always >= 1 for size <= 12.
  assign w_to4k = (32'(AXI_4KB_BOUNDARY) - 32'(i_addr[BW_4KB_OFFSET-1:0])) >> i_size;
  assign w_rem  = 32'(i_remaining);
  assign w_cap  = (w_rem < 32'(MAX_BURST_LEN)) ? w_rem : 32'(MAX_BURST_LEN);
  assign w_min  = (w_cap < w_to4k) ? w_cap : w_to4k;

  assign o_beats     = w_min[BW_NUM_BEAT-1:0];
  assign o_next_addr = i_addr + (BW_ADDR'(o_beats) << i_size);

endmodule

// File: rtl/axi_burst_splitter.sv
// Splits one transfer command into 4 KB-safe AXI INCR address requests.
// Optional burst counter output enabled by defining AXI_BURST_SPLITTER_STAT_EN.
module axi_burst_splitter
  import axi_burst_splitter_pkg::*;
#(
  parameter int BW_ADDR       = 32,
  parameter int BW_AXI_TID    = 4,
  parameter int BW_NUM_BEAT   = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [BW_ADDR-1:0]        cmd_addr,
  input  logic [BW_NUM_BEAT-1:0]    cmd_num_beat,
  input  logic [`BW_AXI_ASIZE-1:0]  cmd_size,
  input  logic [BW_AXI_TID-1:0]     cmd_id,
  output logic [BW_AXI_TID-1:0]     axid,
  output logic [BW_ADDR-1:0]        axaddr,
  output logic [`BW_AXI_ALEN-1:0]   axlen,
  output logic [`BW_AXI_ASIZE-1:0]  axsize,
  output logic [`BW_AXI_ABURST-1:0] axburst,
  output logic                      axvalid,
  input  logic                      axready,
  output logic                      busy,
  output logic                      done
`ifdef AXI_BURST_SPLITTER_STAT_EN
  ,
  output logic [31:0]               stat_num_burst
`endif
);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [BW_ADDR-1:0]         r_addr;
  logic [BW_NUM_BEAT-1:0]     r_remaining;
  logic [BW_NUM_BEAT-1:0]     r_beats;
  logic [BW_ADDR-1:0]         r_next_addr;
  logic [BW_AXI_TID-1:0]      r_id;
  logic [`BW_AXI_ASIZE-1:0]   r_size;
  logic [BW_AXI_TID-1:0]      r_axid;
  logic [BW_ADDR-1:0]         r_axaddr;
  logic [`BW_AXI_ALEN-1:0]    r_axlen;
  logic [`BW_AXI_ASIZE-1:0]   r_axsize;

  logic [BW_NUM_BEAT-1:0]     w_beats;
  logic [BW_NUM_BEAT-1:0]     w_beats_m1;
  logic [BW_ADDR-1:0]         w_next_addr;
  logic [BW_ADDR-1:0]         w_cmd_addr_aligned;
  logic                       w_cmd_hs;
  logic                       w_ax_hs;

  axi_burst_len_calc #(
    .BW_ADDR       (BW_ADDR),
    .BW_NUM_BEAT   (BW_NUM_BEAT),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len_calc (
    .i_addr      (r_addr),
    .i_remaining (r_remaining),
    .i_size      (r_size),
    .o_beats     (w_beats),
    .o_next_addr (w_next_addr)
  );

  assign w_cmd_hs           = (r_state == ST_IDLE) && cmd_valid;
  assign w_ax_hs            = (r_state == ST_ISSUE) && axready;
  assign w_beats_m1         = w_beats - BW_NUM_BEAT'(1);
  assign w_cmd_addr_aligned = cmd_addr & ({BW_ADDR{1'b1}} << cmd_size);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    axvalid      = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_state_next = (cmd_num_beat == '0) ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        axvalid = 1'b1;
        if (axready) begin
          w_state_next = (r_remaining != r_beats) ? ST_CALC : ST_FIN;
        end
      end
      ST_FIN: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Burst payload is captured in CALC so it stays frozen for the whole ISSUE phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_next_addr <= '0;
      r_id        <= '0;
      r_size      <= '0;
      r_axid      <= '0;
      r_axaddr    <= '0;
      r_axlen     <= '0;
      r_axsize    <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr      <= w_cmd_addr_aligned;
        r_remaining <= cmd_num_beat;
        r_id        <= cmd_id;
        r_size      <= cmd_size;
      end
      if (r_state == ST_CALC) begin
        r_beats     <= w_beats;
        r_next_addr <= w_next_addr;
        r_axaddr    <= r_addr;
        r_axlen     <= `BW_AXI_ALEN'(w_beats_m1);
        r_axid      <= r_id;
        r_axsize    <= r_size;
      end
      if (w_ax_hs) begin
        r_addr      <= r_next_addr;
        r_remaining <= r_remaining - r_beats;
      end
    end
  end

  assign axid    = r_axid;
  assign axaddr  = r_axaddr;
  assign axlen   = r_axlen;
  assign axsize  = r_axsize;
  assign axburst = AXI_BURST_INCR;

`ifdef AXI_BURST_SPLITTER_STAT_EN
  logic [31:0] r_stat_num_burst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_num_burst <= '0;
    end else if (w_ax_hs) begin
      r_stat_num_burst <= r_stat_num_burst + 32'd1;
    end
  end

  assign stat_num_burst = r_stat_num_burst;
`endif

endmodule
